// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI frame master and its byte engine.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        GAP,
        TRAIL,
        DONE
    } state_e;

    // Largest payload is 64 bits, so the byte index never exceeds 8.
    localparam int BYTE_CNT_W = $clog2(8 + 1);

    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/spi_frame_master_byte.sv
// spi_byte_engine: shifts one byte out on mosi and in from miso.
// Each bit lasts two sclk half-periods of CLK_DIV clk cycles each.
module spi_byte_engine #(
    parameter int CLK_DIV = 50,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             active_q;
    logic             second_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [7:0]       tx_sh_q;
    logic [7:0]       rx_sh_q;
    logic             sclk_q;
    logic             mosi_q;

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign byte_done = active_q && second_q && (div_q == '0) && (bit_q == 3'd7);
    // With CPHA=1 the last bit is sampled on the very edge that ends the byte.
    assign rx_byte   = CPHA ? {rx_sh_q[6:0], miso} : rx_sh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            second_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
            sclk_q   <= CPOL;
            mosi_q   <= 1'b0;
        end else if (byte_start) begin
            active_q <= 1'b1;
            second_q <= 1'b0;
            div_q    <= DIV_W'(CLK_DIV - 1);
            bit_q    <= '0;
            tx_sh_q  <= CPHA ? tx_byte : {tx_byte[6:0], 1'b0};
            mosi_q   <= tx_byte[7];
            sclk_q   <= CPOL;
        end else if (active_q) begin
            if (div_q != '0) begin
                div_q <= div_q - 1'b1;
            end else begin
                div_q  <= DIV_W'(CLK_DIV - 1);
                sclk_q <= ~sclk_q;
                if (!second_q) begin
                    second_q <= 1'b1;
                    if (CPHA) begin
                        mosi_q  <= tx_sh_q[7];
                        tx_sh_q <= tx_sh_q << 1;
                    end else begin
                        rx_sh_q <= {rx_sh_q[6:0], miso};
                    end
                end else begin
                    second_q <= 1'b0;
                    if (CPHA) begin
                        rx_sh_q <= {rx_sh_q[6:0], miso};
                    end else if (bit_q != 3'd7) begin
                        mosi_q  <= tx_sh_q[7];
                        tx_sh_q <= tx_sh_q << 1;
                    end
                    if (bit_q == 3'd7) begin
                        active_q <= 1'b0;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI frame master: one DATA_W-bit word as NBYTES bytes inside one ss_n window.
//   state | meaning
//   IDLE  | ss_n high, waiting for start
//   LEAD  | ss_n low, sclk idle for CLK_DIV cycles before the first byte
//   XFER  | byte engine shifting one byte
//   GAP   | ss_n low, sclk idle for GAP_CYCLES between bytes
//   TRAIL | ss_n low, sclk idle for CLK_DIV cycles after the last byte
//   DONE  | one cycle: ss_n high, done pulse, rx_word updated, new start accepted
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int DATA_W         = 14,
    parameter int CLK_DIV        = 50,
    parameter bit CPOL           = 1'b0,
    parameter bit CPHA           = 1'b0,
    parameter bit MSB_BYTE_FIRST = 1'b1,
    parameter int GAP_CYCLES     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_word,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_word,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss_n
);

    localparam int NB      = nbytes(DATA_W);
    localparam int TXW     = NB * 8;
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [BYTE_CNT_W-1:0]   idx_q;
    logic [TXW-1:0]          tx_q;
    logic [TXW-1:0]          rx_buf_q;
    logic [DATA_W-1:0]       rx_word_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    ss_n_q;
    logic                    mosi_q;

    logic [TXW-1:0] tx_ext;
    logic [7:0]     cur_byte;
    logic           first_msb;
    logic           more_bytes;
    logic           byte_start;
    logic           byte_done;
    logic [7:0]     eng_rx;
    logic           eng_mosi;

    // tx_q always presents the next byte to send in its outgoing slot.
    assign tx_ext     = TXW'(tx_word);
    assign cur_byte   = MSB_BYTE_FIRST ? tx_q[TXW-1 -: 8] : tx_q[7:0];
    assign first_msb  = MSB_BYTE_FIRST ? tx_ext[TXW-1] : tx_ext[7];
    assign more_bytes = (idx_q != BYTE_CNT_W'(NB));

    assign byte_start = ((state_q == LEAD) && (cnt_q == '0)) ||
                        ((state_q == GAP)  && (cnt_q == '0)) ||
                        ((state_q == XFER) && byte_done && more_bytes && (GAP_CYCLES == 0));

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_word = rx_word_q;
    assign ss_n    = ss_n_q;
    assign mosi    = (state_q == XFER) ? eng_mosi : mosi_q;

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL),
        .CPHA    (CPHA)
    ) u_byte_engine (
        .clk        (clk),
        .reset      (reset),
        .byte_start (byte_start),
        .tx_byte    (cur_byte),
        .rx_byte    (eng_rx),
        .byte_done  (byte_done),
        .sclk       (sclk),
        .mosi       (eng_mosi),
        .miso       (miso)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_q      <= '0;
            rx_buf_q  <= '0;
            rx_word_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (byte_start) begin
                tx_q  <= MSB_BYTE_FIRST ? (tx_q << 8) : (tx_q >> 8);
                idx_q <= idx_q + 1'b1;
            end
            // Bytes arrive in send order; shifting them in rebuilds the word.
            if (byte_done) begin
                rx_buf_q <= MSB_BYTE_FIRST ? TXW'({rx_buf_q, eng_rx})
                                           : TXW'({eng_rx, rx_buf_q} >> 8);
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= LEAD;
                        tx_q    <= tx_ext;
                        idx_q   <= '0;
                        cnt_q   <= CNT_W'(CLK_DIV - 1);
                        ss_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        if (!CPHA) begin
                            mosi_q <= first_msb;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LEAD: begin
                    if (cnt_q == '0) begin
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                XFER: begin
                    if (byte_done) begin
                        if (more_bytes) begin
                            if (GAP_CYCLES != 0) begin
                                state_q <= GAP;
                                cnt_q   <= CNT_W'(GAP_CYCLES - 1);
                                mosi_q  <= cur_byte[7];
                            end
                        end else begin
                            state_q <= TRAIL;
                            cnt_q   <= CNT_W'(CLK_DIV - 1);
                            mosi_q  <= eng_mosi;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= XFER;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                TRAIL: begin
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        ss_n_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_word_q <= DATA_W'(rx_buf_q);
                        mosi_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: three configurations sharing clk and reset.
module tb_spi_frame_master;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // A: 14-bit, mode 0, MSB byte first, gap 2, loopback
    logic        start_a, busy_a, done_a, sclk_a, mosi_a, miso_a, ss_n_a;
    logic [13:0] tx_a, rx_a;
    assign miso_a = mosi_a;

    // B: as A but LSB byte first; miso can be forced high
    logic        start_b, busy_b, done_b, sclk_b, mosi_b, miso_b, ss_n_b, force_b;
    logic [13:0] tx_b, rx_b;
    assign miso_b = force_b ? 1'b1 : mosi_b;

    // C: 8-bit, CPOL=1 CPHA=1, no gap, loopback
    logic        start_c, busy_c, done_c, sclk_c, mosi_c, miso_c, ss_n_c;
    logic [7:0]  tx_c, rx_c;
    assign miso_c = mosi_c;

    spi_frame_master #(.DATA_W(14), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0),
                       .MSB_BYTE_FIRST(1'b1), .GAP_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .tx_word(tx_a), .busy(busy_a),
        .done(done_a), .rx_word(rx_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a),
        .ss_n(ss_n_a));

    spi_frame_master #(.DATA_W(14), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0),
                       .MSB_BYTE_FIRST(1'b0), .GAP_CYCLES(2)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .tx_word(tx_b), .busy(busy_b),
        .done(done_b), .rx_word(rx_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b),
        .ss_n(ss_n_b));

    spi_frame_master #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1),
                       .MSB_BYTE_FIRST(1'b1), .GAP_CYCLES(0)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .tx_word(tx_c), .busy(busy_c),
        .done(done_c), .rx_word(rx_c), .sclk(sclk_c), .mosi(mosi_c), .miso(miso_c),
        .ss_n(ss_n_c));

    // Slave-side monitors: ss_n-low cycle counts, done pulse counts, mosi bits
    // captured on rising sclk (the sampling edge in both modes used here).
    int          low_a = 0, low_b = 0, low_c = 0;
    int          dn_a = 0, dn_b = 0, dn_c = 0;
    logic [63:0] cap_a = '0, cap_b = '0, cap_c = '0;

    always @(posedge clk) begin
        if (ss_n_a === 1'b0) low_a++;
        if (ss_n_b === 1'b0) low_b++;
        if (ss_n_c === 1'b0) low_c++;
        if (done_a === 1'b1) dn_a++;
        if (done_b === 1'b1) dn_b++;
        if (done_c === 1'b1) dn_c++;
    end

    always @(posedge sclk_a) if (ss_n_a === 1'b0) cap_a = {cap_a[62:0], mosi_a};
    always @(posedge sclk_b) if (ss_n_b === 1'b0) cap_b = {cap_b[62:0], mosi_b};
    always @(posedge sclk_c) if (ss_n_c === 1'b0) cap_c = {cap_c[62:0], mosi_c};

    int n_tests = 0;
    int n_fail  = 0;
    int l0, d0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic wait_done(input int w, input string tag);
        int n = 0;
        while (done_of(w) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_of(w)), 64'd1);
    endtask

    task automatic pulse_a(input logic [13:0] w);
        start_a = 1'b1; tx_a = w;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [13:0] w);
        start_b = 1'b1; tx_b = w;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic pulse_c(input logic [7:0] w);
        start_c = 1'b1; tx_c = w;
        @(negedge clk);
        start_c = 1'b0;
    endtask

    initial begin
        reset = 1'b1; force_b = 1'b0;
        start_a = 1'b0; tx_a = '0;
        start_b = 1'b0; tx_b = '0;
        start_c = 1'b0; tx_c = '0;
        repeat (3) @(negedge clk);

        check("rst_busy",   64'(busy_a), 64'd0);
        check("rst_done",   64'(done_a), 64'd0);
        check("rst_rx",     64'(rx_a),   64'd0);
        check("rst_sclk_a", 64'(sclk_a), 64'd0);
        check("rst_mosi",   64'(mosi_a), 64'd0);
        check("rst_ss_n",   64'(ss_n_a), 64'd1);
        check("rst_sclk_c", 64'(sclk_c), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // 1: MSB byte first, loopback
        l0 = low_a; d0 = dn_a;
        pulse_a(14'h2A5C);
        check("t1_ss_low_after_accept", 64'(ss_n_a), 64'd0);
        check("t1_busy_after_accept",   64'(busy_a), 64'd1);
        wait_done(0, "t1");
        check("t1_busy_in_done", 64'(busy_a), 64'd0);
        check("t1_ss_n_in_done", 64'(ss_n_a), 64'd1);
        check("t1_rx",           64'(rx_a),   64'h2A5C);
        check("t1_ss_low_cyc",   64'(low_a - l0), 64'd70);
        check("t1_mosi_bytes",   64'(cap_a[15:0]), 64'h2A5C);
        @(negedge clk);
        check("t1_done_pulses",  64'(dn_a - d0), 64'd1);
        check("t1_done_cleared", 64'(done_a), 64'd0);

        // 2: LSB byte first, loopback, then miso stuck high
        l0 = low_b;
        pulse_b(14'h3FFF);
        wait_done(1, "t2a");
        check("t2a_rx",         64'(rx_b), 64'h3FFF);
        check("t2a_mosi_bytes", 64'(cap_b[15:0]), 64'hFF3F);
        check("t2a_ss_low_cyc", 64'(low_b - l0), 64'd70);
        repeat (2) @(negedge clk);
        pulse_b(14'h1234);
        wait_done(1, "t2b");
        check("t2b_rx",         64'(rx_b), 64'h1234);
        check("t2b_mosi_bytes", 64'(cap_b[15:0]), 64'h3412);
        repeat (2) @(negedge clk);
        force_b = 1'b1;
        pulse_b(14'h0000);
        wait_done(1, "t2c");
        check("t2c_rx_pad_dropped", 64'(rx_b), 64'h3FFF);
        check("t2c_mosi_bytes",     64'(cap_b[15:0]), 64'h0000);
        force_b = 1'b0;

        // 3: CPOL=1 CPHA=1 single byte
        l0 = low_c; d0 = dn_c;
        check("t3_sclk_idle_before", 64'(sclk_c), 64'd1);
        pulse_c(8'hA5);
        check("t3_sclk_idle_lead", 64'(sclk_c), 64'd1);
        wait_done(2, "t3");
        check("t3_rx",           64'(rx_c), 64'hA5);
        check("t3_mosi_byte",    64'(cap_c[7:0]), 64'hA5);
        check("t3_ss_low_cyc",   64'(low_c - l0), 64'd36);
        check("t3_sclk_idle_end", 64'(sclk_c), 64'd1);
        @(negedge clk);
        check("t3_done_pulses",  64'(dn_c - d0), 64'd1);

        // 4: start while busy is ignored, tx_word changes mid-frame are ignored
        repeat (2) @(negedge clk);
        l0 = low_a; d0 = dn_a;
        pulse_a(14'h1234);
        repeat (10) @(negedge clk);
        check("t4_busy_mid", 64'(busy_a), 64'd1);
        start_a = 1'b1; tx_a = 14'h1111;
        @(negedge clk);
        start_a = 1'b0; tx_a = 14'h0000;
        wait_done(0, "t4a");
        check("t4a_rx",         64'(rx_a), 64'h1234);
        check("t4a_mosi_bytes", 64'(cap_a[15:0]), 64'h1234);
        check("t4a_ss_low_cyc", 64'(low_a - l0), 64'd70);
        @(negedge clk);
        check("t4a_done_pulses", 64'(dn_a - d0), 64'd1);
        repeat (2) @(negedge clk);
        pulse_a(14'h1111);
        wait_done(0, "t4b");
        check("t4b_rx",         64'(rx_a), 64'h1111);
        check("t4b_mosi_bytes", 64'(cap_a[15:0]), 64'h1111);
        repeat (2) @(negedge clk);

        // 5: back-to-back frames via start in the done cycle
        l0 = low_a; d0 = dn_a;
        pulse_a(14'h0ABC);
        wait_done(0, "t5a");
        check("t5a_rx",        64'(rx_a),   64'h0ABC);
        check("t5a_ss_n_done", 64'(ss_n_a), 64'd1);
        start_a = 1'b1; tx_a = 14'h1555;
        @(negedge clk);
        start_a = 1'b0;
        check("t5b_ss_low_next", 64'(ss_n_a), 64'd0);
        check("t5b_busy_next",   64'(busy_a), 64'd1);
        wait_done(0, "t5b");
        check("t5b_rx",          64'(rx_a), 64'h1555);
        check("t5_mosi_stream",  64'(cap_a[31:0]), 64'h0ABC1555);
        check("t5_ss_low_cyc",   64'(low_a - l0), 64'd140);
        @(negedge clk);
        check("t5_done_pulses",  64'(dn_a - d0), 64'd2);
        repeat (2) @(negedge clk);

        // 6: reset during the second byte
        d0 = dn_a;
        pulse_a(14'h2222);
        repeat (45) @(negedge clk);
        check("t6_busy_before_rst", 64'(busy_a), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_ss_n_async", 64'(ss_n_a), 64'd1);
        check("t6_sclk_async", 64'(sclk_a), 64'd0);
        check("t6_busy_async", 64'(busy_a), 64'd0);
        check("t6_rx_cleared", 64'(rx_a),   64'd0);
        check("t6_sclk_c_idle", 64'(sclk_c), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_done", 64'(dn_a - d0), 64'd0);
        check("t6_rx_held", 64'(rx_a), 64'd0);
        l0 = low_a;
        pulse_a(14'h3333);
        wait_done(0, "t6b");
        check("t6b_rx",         64'(rx_a), 64'h3333);
        check("t6b_mosi_bytes", 64'(cap_a[15:0]), 64'h3333);
        check("t6b_ss_low_cyc", 64'(low_a - l0), 64'd70);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
